// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered valid/ready ALU with optional iterative multiplier
//
// Purpose: executes one ALU operation per input transfer and holds the result
// and flags in output registers until the consumer takes them.
// Build option: define ALU_MUL_EN to build the shift-and-add multiplier (opcode 12).
// Without it, opcode 12 is reserved and the block is purely single-cycle.
//
// Ports:
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   in_valid / in_ready    request handshake; in_a, in_b, opcode captured on transfer
//   out_valid / out_ready  result handshake
//   out                    result (BW bits)
//   flags                  {carry, overflow, negative, zero}
//   out_illegal            result came from a reserved opcode
module alu_pipe #(
  parameter int BW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_a,
  input  logic [BW-1:0] in_b,
  input  logic [3:0]    opcode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BW-1:0] out,
  output logic [3:0]    flags,
  output logic          out_illegal
);

  localparam int SW = $clog2(BW);
  localparam logic [BW-1:0] ONE     = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW:0]   ONE_W   = {{BW{1'b0}}, 1'b1};
  localparam logic [BW-1:0] MAX_POS = {1'b0, {(BW-1){1'b1}}};
  localparam logic [BW-1:0] MIN_NEG = {1'b1, {(BW-1){1'b0}}};

  logic [SW-1:0] shamt;
  logic          a_msb;
  logic          b_msb;
  logic [BW:0]   wide;
  logic [BW-1:0] res;
  logic          c_f;
  logic          v_f;
  logic          ill;
  logic          slot_free;
  logic          accept;
  logic          load_alu;

  assign shamt     = in_b[SW-1:0];
  assign a_msb     = in_a[BW-1];
  assign b_msb     = in_b[BW-1];
  assign slot_free = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;

  // Single-cycle operations. Reserved opcodes fall to the default arm, which
  // leaves result and C/V at zero so Z alone is set.
  always_comb begin
    wide = '0;
    res  = '0;
    c_f  = 1'b0;
    v_f  = 1'b0;
    ill  = 1'b0;
    case (opcode)
      4'd0: begin
        wide = {1'b0, in_a} + {1'b0, in_b};
        res  = wide[BW-1:0];
        c_f  = wide[BW];
        v_f  = (a_msb == b_msb) && (res[BW-1] != a_msb);
      end
      4'd1: begin
        // Top bit of the widened difference is the borrow.
        wide = {1'b0, in_a} - {1'b0, in_b};
        res  = wide[BW-1:0];
        c_f  = wide[BW];
        v_f  = (a_msb != b_msb) && (res[BW-1] != a_msb);
      end
      4'd2: res = in_a & in_b;
      4'd3: res = in_a | in_b;
      4'd4: res = in_a ^ in_b;
      4'd5: begin
        wide = {1'b0, in_a} + ONE_W;
        res  = wide[BW-1:0];
        c_f  = wide[BW];
        v_f  = (in_a == MAX_POS);
      end
      4'd6: res = in_a;
      4'd7: res = in_b;
      4'd8: begin
        res = in_a - ONE;
        c_f = (in_a == '0);
        v_f = (in_a == MIN_NEG);
      end
      4'd9: begin
        // Extra bit above the operand catches the last bit shifted out.
        wide = {1'b0, in_a} << shamt;
        res  = wide[BW-1:0];
        c_f  = wide[BW];
      end
      4'd10: begin
        // Extra bit below the operand catches the last bit shifted out.
        wide = {in_a, 1'b0} >> shamt;
        res  = wide[BW:1];
        c_f  = wide[0];
      end
      4'd11: begin
        wide = $signed({in_a, 1'b0}) >>> shamt;
        res  = wide[BW:1];
        c_f  = wide[0];
      end
      default: ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [SW:0] CNT_INIT = (SW+1)'(BW);
  localparam logic [SW:0] CNT_ONE  = {{SW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic [SW:0]     cnt;
  logic [BW-1:0]   mcand;
  logic [BW-1:0]   mplier;
  logic [2*BW-1:0] acc;
  logic [BW:0]     acc_sum;
  logic            is_mul_op;
  logic            start_mul;
  logic            load_mul;

  assign is_mul_op = (opcode == 4'd12);
  // Add the multiplicand into the upper half when the current multiplier bit is set.
  assign acc_sum   = {1'b0, acc[2*BW-1:BW]} + (mplier[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul_op) state_nxt = S_MUL;
      S_MUL:   if (cnt == CNT_ONE)      state_nxt = S_DONE;
      S_DONE:  if (slot_free)           state_nxt = S_IDLE;
      default:                          state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE) && slot_free;
    start_mul = (state == S_IDLE) && accept && is_mul_op;
    load_alu  = (state == S_IDLE) && accept && !is_mul_op;
    load_mul  = (state == S_DONE) && slot_free;
  end

  // Right-shifting accumulator: after BW steps it holds the full 2*BW product.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start_mul) begin
      acc    <= '0;
      cnt    <= CNT_INIT;
      mcand  <= in_a;
      mplier <= in_b;
    end else if (state == S_MUL) begin
      acc    <= {acc_sum, acc[BW-1:1]};
      mplier <= mplier >> 1;
      cnt    <= cnt - CNT_ONE;
    end
  end
`else
  assign in_ready = slot_free;
  assign load_alu = accept;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out         <= '0;
      flags       <= 4'b0000;
      out_illegal <= 1'b0;
    end else if (load_alu) begin
      out_valid   <= 1'b1;
      out         <= res;
      flags       <= {c_f, v_f, res[BW-1], (res == '0)};
      out_illegal <= ill;
`ifdef ALU_MUL_EN
    end else if (load_mul) begin
      out_valid   <= 1'b1;
      out         <= acc[BW-1:0];
      flags       <= {|acc[2*BW-1:BW], 1'b0, acc[BW-1], (acc[BW-1:0] == '0)};
      out_illegal <= 1'b0;
`endif
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - self-checking bench for alu_pipe (honours ALU_MUL_EN)
`timescale 1ns/1ps
module tb_alu_pipe;
  localparam int BW = 16;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_a = '0;
  logic [BW-1:0] in_b = '0;
  logic [3:0]    opcode = 4'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out;
  logic [3:0]    flags;
  logic          out_illegal;

  always #5 clk = ~clk;

  alu_pipe #(.BW(BW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .opcode(opcode), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .flags(flags), .out_illegal(out_illegal)
  );

  typedef struct {
    logic [BW-1:0] res;
    logic [3:0]    flags;
    logic          ill;
    bit            vis;
    int            wait_cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   seen;
  bit   mon_en = 1'b0;
  bit   m_ev;
  bit   m_busy;
  exp_t m_e;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference behaviour from plain integer arithmetic.
  function automatic exp_t ref_op(input int op, input longint a, input longint b);
    longint m = 64'd1 << BW;
    longint hi = m / 2;
    longint sa, sb, full, r;
    int s;
    bit c = 0, v = 0, ill = 0;
    exp_t e;
    sa = (a >= hi) ? a - m : a;
    sb = (b >= hi) ? b - m : b;
    s  = int'(b % BW);
    r  = 0;
    case (op)
      0: begin full = a + b; r = full % m; c = (full >= m); v = (sa + sb >= hi) || (sa + sb < -hi); end
      1: begin r = (a - b + m) % m; c = (a < b); v = (sa - sb >= hi) || (sa - sb < -hi); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin full = a + 1; r = full % m; c = (full >= m); v = (sa + 1 >= hi); end
      6: r = a;
      7: r = b;
      8: begin r = (a + m - 1) % m; c = (a == 0); v = (sa - 1 < -hi); end
      9: begin r = (a << s) % m; c = (s != 0) && (((a >> (BW - s)) & 1) == 1); end
      10: begin r = a >> s; c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      11: begin r = (sa >>> s) & (m - 1); c = (s != 0) && (((a >> (s - 1)) & 1) == 1); end
      12: if (MUL_EN) begin full = a * b; r = full % m; c = ((full / m) != 0); end
          else ill = 1;
      default: ill = 1;
    endcase
    e.res = r[BW-1:0];
    e.flags = {c, v, (r >= hi), (r == 0)};
    e.ill = ill;
    e.vis = 1'b1;
    e.wait_cnt = 0;
    return e;
  endfunction

  function automatic bit mul_busy();
    foreach (q[i]) if (!q[i].vis) return 1'b1;
    return 1'b0;
  endfunction

  // Model update at each active edge, using pre-edge inputs.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      mon_en = 1'b1;
    end else if (mon_en) begin
      m_ev   = (q.size() > 0) && q[0].vis;
      m_busy = mul_busy();
      if (m_ev && out_ready) void'(q.pop_front());
      for (int i = 0; i < q.size(); i++) begin
        if (!q[i].vis) begin
          if (q[i].wait_cnt > 0) q[i].wait_cnt--;
          if (q[i].wait_cnt == 0 && i == 0) q[i].vis = 1'b1;
        end
      end
      if (in_valid && !m_busy && (!m_ev || out_ready)) begin
        m_e = ref_op(int'(opcode), longint'(in_a), longint'(in_b));
        if (MUL_EN && opcode == 4'd12) begin
          m_e.vis = 1'b0;
          m_e.wait_cnt = BW + 1;
        end
        q.push_back(m_e);
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (mon_en) begin
      automatic bit ev = (q.size() > 0) && q[0].vis;
      automatic bit busy = mul_busy();
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, !busy && (!ev || out_ready));
      if (ev) begin
        chk("out", out, q[0].res);
        chk("flags", flags, q[0].flags);
        chk("out_illegal", out_illegal, q[0].ill);
      end
    end
  end

  task automatic do_op(input string name, input int op, input logic [BW-1:0] a, input logic [BW-1:0] b,
                       input logic [BW-1:0] er, input logic [3:0] ef, input logic ei);
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = op[3:0]; in_a = a; in_b = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_out"}, out, er);
    chk({name, "_flags"}, flags, ef);
    chk({name, "_illegal"}, out_illegal, ei);
  endtask

  function automatic logic [BW-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    // Model pinned to hand-computed values.
    chk("model_add_flags", ref_op(0, 'h7FFF, 1).flags, 4'b0110);
    chk("model_sub_res", ref_op(1, 3, 5).res, 16'hFFFE);
    chk("model_sra_res", ref_op(11, 'h8000, 15).res, 16'hFFFF);
    chk("model_shr_flags", ref_op(10, 'h0003, 1).flags, 4'b1000);

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_valid", out_valid, 0);
    chk("reset_out", out, 0);
    chk("reset_flags", flags, 0);
    chk("reset_illegal", out_illegal, 0);
    chk("reset_in_ready", in_ready, 1);

    do_op("add_ovf", 0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110, 1'b0);
    do_op("add_carry", 0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001, 1'b0);
    do_op("sub_borrow", 1, 16'h0003, 16'h0005, 16'hFFFE, 4'b1010, 1'b0);
    do_op("dec_ovf", 8, 16'h8000, 16'h0000, 16'h7FFF, 4'b0100, 1'b0);
    do_op("shl", 9, 16'h8001, 16'h0001, 16'h0002, 4'b1000, 1'b0);
    do_op("sra", 11, 16'h8000, 16'h000F, 16'hFFFF, 4'b0010, 1'b0);
    do_op("op13", 13, 16'h1234, 16'h5678, 16'h0000, 4'b0001, 1'b1);
`ifndef ALU_MUL_EN
    do_op("op12_off", 12, 16'h0100, 16'h0100, 16'h0000, 4'b0001, 1'b1);
`endif

    // Backpressure then simultaneous consume and accept.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; opcode = 4'd0; in_a = 16'd1; in_b = 16'd2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out", out, 3);
      chk("bp_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1; opcode = 4'd4; in_a = 16'h00F5; in_b = 16'h0033;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_xor_valid", out_valid, 1);
    chk("bp_xor_out", out, 16'h00C6);

`ifdef ALU_MUL_EN
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 4'd12; in_a = 16'h0100; in_b = 16'h0100; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < BW + 1; i++) begin
      @(negedge clk);
      chk("mul_in_ready_low", in_ready, 0);
      chk("mul_not_yet_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("mul_valid", out_valid, 1);
    chk("mul_out", out, 0);
    chk("mul_flags", flags, 4'b1001);
    chk("mul_illegal", out_illegal, 0);

    // Reset mid-multiply must abandon it.
    @(posedge clk); #1;
    in_valid = 1'b1; opcode = 4'd12; in_a = 16'd3; in_b = 16'd5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 0;
    repeat (BW + 5) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mul_reset_no_result", seen, 0);
`endif

    // Randomized traffic with random backpressure and occasional resets.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(posedge clk); #1;
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      opcode    = 4'($urandom_range(0, 15));
      in_a      = pick();
      in_b      = pick();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (BW + 4) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Registered, handshaked successor of the datapath ALU. Accepts one operation per transfer on a valid/ready input channel and returns the result and flags on a valid/ready output channel. Extends the 8-operation set with DEC, shifts and an iterative multiply, adds a carry flag, and flags illegal opcodes. Sits between the operand fetch stage and the writeback stage of the processor datapath.

## Interface
- `BW`, 16, operand/result width in bits; legal range BW ≥ 4.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_valid` input 1: operation request is valid.
- `in_ready` output 1: block can accept a request this cycle.
- `in_a` input BW: operand A, unsigned bit vector.
- `in_b` input BW: operand B, unsigned bit vector.
- `opcode` input 4: operation select.
- `out_valid` output 1: result registers hold an unconsumed result.
- `out_ready` input 1: consumer takes the result this cycle.
- `out` output BW: result.
- `flags` output 4: {carry, overflow, negative, zero}.
- `out_illegal` output 1: the result came from a reserved opcode.

## Operation
- A transfer happens on a cycle with `in_valid && in_ready`. Operands and opcode are captured at that edge.
- Opcodes:
  - 0 ADD: a+b. C = carry out. V = signed overflow.
  - 1 SUB: a−b. C = borrow (a<b unsigned). V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C=V=0.
  - 5 INC: a+1. C = carry out. V = (a == 0111…1).
  - 6 MOVA: result a. 7 MOVB: result b. C=V=0.
  - 8 DEC: a−1. C = (a == 0). V = (a == 1000…0).
  - 9 SHL, 10 SHR (logical), 11 SRA (arithmetic): shift a by s = `in_b[$clog2(BW)-1:0]`. C = last bit shifted out, or 0 when s=0. V=0.
  - 12 MUL: low BW bits of a×b, unsigned. C = 1 if the high BW bits of the full 2·BW product are nonzero. V=0.
  - 13–15 reserved: result 0, flags 4'b0001, `out_illegal`=1.
- N = result[BW-1]. Z = (result == 0), for every opcode.
- `out_illegal` is 0 for all legal opcodes.
- All arithmetic is mod 2^BW on `out`. Internal sums use BW+1 bits so the carry is available.
- FSM states:
  - IDLE: `in_ready` = !out_valid || out_ready. A non-MUL transfer loads the result registers and stays in IDLE. A MUL transfer clears the accumulator, loads the counter with BW and goes to MUL.
  - MUL: shift-and-add, one multiplier bit (LSB first) per cycle, counter decrements. `in_ready`=0. When the counter reaches 0, go to DONE.
  - DONE: `in_ready`=0. Load the result registers when the output slot is free (!out_valid || out_ready), then go to IDLE.
- Output channel:
  - `out_valid` is set when the result registers are loaded.
  - `out_valid` clears on `out_valid && out_ready` unless the registers are reloaded on the same edge.
  - `out`, `flags` and `out_illegal` stay stable while `out_valid && !out_ready`.
- Simultaneous consume and accept in IDLE: the old result is consumed and the new single-cycle result loads on the same edge. `out_valid` stays 1.

## Timing
- Reset (`rst_n`=0 at a rising edge):
  - state → IDLE; `out_valid`=0, `out`=0, `flags`=4'b0000, `out_illegal`=0.
  - `in_ready`=1 in the first cycle after reset.
  - Reset mid-MUL abandons the multiply; no result is produced.
- Single-cycle ops: request accepted at edge k; result and `out_valid` visible after edge k. Latency 1. With `out_ready` held high, throughput is 1 per cycle.
- MUL: accepted at edge k; result loaded at edge k+BW+1 if the output slot is free, otherwise later. `in_ready`=0 from after edge k until the result is loaded.
- Backpressure: while `out_valid && !out_ready` in IDLE, `in_ready`=0. Nothing is dropped.
- `in_a`, `in_b` and `opcode` are don't-care when no transfer occurs.

## Configuration
- `ALU_MUL_EN` defined:
  - The MUL state, counter and accumulator are built.
  - Opcode 12 behaves as specified above.
- `ALU_MUL_EN` not defined:
  - No multiplier logic is built.
  - Opcode 12 is reserved: single-cycle result 0, flags 4'b0001, `out_illegal`=1.
  - The FSM never leaves IDLE.

## Test plan
- Reset, BW=16: hold `rst_n`=0 for 2 cycles, then release. Required: `out_valid`=0, `out`=0, `flags`=0, `in_ready`=1.
- ADD 0x7FFF+0x0001 → `out`=0x8000, flags=4'b0110. ADD 0xFFFF+0x0001 → `out`=0x0000, flags=4'b1001. Each result appears one cycle after acceptance, with `out_ready`=1.
- SUB 0x0003−0x0005 → 0xFFFE, flags=4'b1010. DEC 0x8000 → 0x7FFF, flags=4'b0100. SHL 0x8001 by 1 → 0x0002, C=1. SRA 0x8000 by 15 → 0xFFFF, flags=4'b0010.
- MUL 0x0100×0x0100, `ALU_MUL_EN` defined → `out`=0x0000, flags=4'b1001. The result arrives at edge k+17, and `in_ready`=0 throughout.
- Backpressure: issue ADD 1+2 with `out_ready`=0 for 3 cycles. Required: `out`=3 held, `in_ready`=0. Raise `out_ready` together with a new XOR request. Required: the next edge shows the XOR result with `out_valid` still 1.
- Opcode 13, and opcode 12 with `ALU_MUL_EN` undefined → `out`=0, flags=4'b0001, `out_illegal`=1, latency 1. Separately, assert reset mid-MUL → no result is emitted after reset.
